// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/ack, decode valid/ready, extender fields and redirect.
// master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [24:0] none_extended_data;
   logic        imm_src;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, none_extended_data, imm_src,
      input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, none_extended_data, imm_src,
      output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// RISC-V fetch stage: one request per instruction, result valid the cycle after ACK (1 instr / 2 cycles peak).
// Decode backpressure holds INSTR and suppresses the next request; redirects drain an in-flight request.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input logic            clk,
   input logic            rst_n,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q;
   logic [31:0] drain_addr_q;
   logic [31:0] instr_q;
   logic [31:0] instr_pc_q;
   logic        instr_vld_q;
   logic [31:0] redirect_tgt;
   logic        accept;
   logic        release_instr;
   logic        req;
   logic [31:0] addr;

   assign redirect_tgt  = bus.redirect_pc & ~32'h3;
   assign accept        = (state_q == FETCH) && bus.imem_ack && !bus.redirect_valid;
   assign release_instr = (state_q == HOLD) && (bus.redirect_valid || bus.instr_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (bus.redirect_valid) state_d = bus.imem_ack ? FETCH : DRAIN;
            else if (bus.imem_ack)  state_d = HOLD;
         end
         HOLD:  if (bus.redirect_valid || bus.instr_ready) state_d = FETCH;
         DRAIN: if (bus.imem_ack) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // The request in flight cannot be cancelled, so DRAIN keeps presenting the pre-redirect address.
   always_comb begin
      req  = 1'b0;
      addr = pc_q;
      case (state_q)
         FETCH: req = 1'b1;
         DRAIN: begin
            req  = 1'b1;
            addr = drain_addr_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         instr_q      <= NOP_INSTR;
         instr_pc_q   <= 32'h0;
         instr_vld_q  <= 1'b0;
      end else begin
         if (bus.redirect_valid) pc_q <= redirect_tgt;
         else if (accept)        pc_q <= pc_q + 32'd4;

         if (state_q == FETCH && bus.redirect_valid && !bus.imem_ack) drain_addr_q <= pc_q;

         if (accept) begin
            instr_q     <= bus.imem_rdata;
            instr_pc_q  <= pc_q;
            instr_vld_q <= 1'b1;
         end else if (release_instr) begin
            instr_q     <= NOP_INSTR;
            instr_vld_q <= 1'b0;
         end
      end
   end

   assign bus.imem_req           = req;
   assign bus.imem_addr          = addr;
   assign bus.instr_valid        = instr_vld_q;
   assign bus.instr              = instr_q;
   assign bus.instr_pc           = instr_pc_q;
   assign bus.none_extended_data = instr_q[31:7];
   assign bus.imm_src            = (instr_q[6:0] == 7'b0100011);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench: memory/decode/redirect driver feeds a program-order scoreboard, monitor checks each delivery.
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus2 ();

   instr_fetch_unit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   int tests = 0;
   int fails = 0;
   int max_lat = 0;
   int rdy_pct = 100;
   int redir_pct = 0;
   int n_deliv = 0;
   int cyc = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_push;
   logic [31:0] log_addr[$];
   int          log_cyc[$];
   logic [31:0] log2[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Program image: fixed lw/sw at 0 and 4, otherwise a hash with a mix of store, load and arbitrary opcodes.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] x;
      if (a == 32'h0) return 32'h0082_A183;
      if (a == 32'h4) return 32'h0062_A423;
      x = a * 32'h9E37_79B1 ^ 32'h5A5A_0000;
      case (a[3:2])
         2'd0:    return {x[31:7], 7'b0100011};
         2'd1:    return {x[31:7], 7'b0000011};
         default: return x;
      endcase
   endfunction

   // Driver: memory with random ACK latency, random decode ready, random redirects.
   // Reference model: next delivered PC is previous+4 after a consume, or the redirect target.
   initial begin
      int lat_left;
      lat_left = -1;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'h0;
      bus.instr_ready = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 32'h0;
      forever begin
         @(negedge clk);
         bus.imem_ack = 1'b0;
         bus.redirect_valid = 1'b0;
         if (!rst_n) begin
            lat_left = -1;
            bus.instr_ready = 1'b0;
            exp_q.delete();
            exp_q.push_back(32'h0);
            last_push = 32'h0;
         end else begin
            if (bus.imem_req) begin
               if (lat_left < 0) lat_left = int'($urandom_range(0, max_lat));
               if (lat_left == 0) begin
                  bus.imem_ack = 1'b1;
                  lat_left = -1;
               end else begin
                  lat_left--;
               end
            end
            bus.imem_rdata = bus.imem_req ? mem_word(bus.imem_addr) : $urandom;
            bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
            bus.redirect_valid = ($urandom_range(0, 99) < redir_pct);
            bus.redirect_pc = {20'h0, 12'($urandom)};
            if (bus.redirect_valid) begin
               exp_q.delete();
               last_push = bus.redirect_pc & ~32'h3;
               exp_q.push_back(last_push);
            end else if (bus.instr_valid && bus.instr_ready) begin
               last_push = last_push + 32'd4;
               exp_q.push_back(last_push);
            end
         end
      end
   end

   // Monitor
   initial begin
      logic        prev_req, prev_valid, prev2_req;
      logic [31:0] prev_addr, prev_instr, prev_pc, prev2_addr, e, w;
      prev_req = 1'b0; prev_valid = 1'b0; prev2_req = 1'b0;
      prev_addr = 32'h0; prev_instr = 32'h0; prev_pc = 32'h0; prev2_addr = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            prev_req = 1'b0; prev_valid = 1'b0; prev2_req = 1'b0;
            continue;
         end
         if (prev2_req && bus2.imem_ack) log2.push_back(prev2_addr);
         prev2_req = bus2.imem_req;
         prev2_addr = bus2.imem_addr;

         if (prev_req && bus.imem_ack) begin
            log_addr.push_back(prev_addr);
            log_cyc.push_back(cyc);
         end
         if (prev_req && !bus.imem_ack) begin
            check("req_held", {31'h0, bus.imem_req}, 32'h1);
            check("addr_held", bus.imem_addr, prev_addr);
         end

         if (!bus.instr_valid) begin
            check("idle_instr_nop", bus.instr, NOP);
            check("idle_imm_src", {31'h0, bus.imm_src}, 32'h0);
         end else if (prev_valid && !bus.instr_ready && !bus.redirect_valid) begin
            check("held_instr", bus.instr, prev_instr);
            check("held_pc", bus.instr_pc, prev_pc);
            check("held_no_req", {31'h0, bus.imem_req}, 32'h0);
         end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_delivery: got pc %h, none expected", bus.instr_pc);
         end else begin
            e = exp_q.pop_front();
            w = mem_word(e);
            n_deliv++;
            check("deliv_pc", bus.instr_pc, e);
            check("deliv_instr", bus.instr, w);
            check("deliv_imm_src", {31'h0, bus.imm_src}, {31'h0, (w[6:0] == 7'b0100011)});
            check("deliv_ned", {7'h0, bus.none_extended_data}, {7'h0, w[31:7]});
         end

         prev_req = bus.imem_req;
         prev_addr = bus.imem_addr;
         prev_valid = bus.instr_valid;
         prev_instr = bus.instr;
         prev_pc = bus.instr_pc;
      end
   end

   initial begin
      bit found;
      int d0;
      rst_n = 1'b0;
      bus2.imem_ack = 1'b1;
      bus2.imem_rdata = NOP;
      bus2.instr_ready = 1'b1;
      bus2.redirect_valid = 1'b0;
      bus2.redirect_pc = 32'h0;

      repeat (3) @(posedge clk);
      #2;
      check("rst_req", {31'h0, bus.imem_req}, 32'h0);
      check("rst_addr", bus.imem_addr, 32'h0);
      check("rst_valid", {31'h0, bus.instr_valid}, 32'h0);
      check("rst_instr", bus.instr, NOP);
      check("rst_instr_pc", bus.instr_pc, 32'h0);
      check("rst_imm_src", {31'h0, bus.imm_src}, 32'h0);
      check("rst_ned", {7'h0, bus.none_extended_data}, 32'h0);
      check("rst_addr2", bus2.imem_addr, 32'hFFFF_FFFC);

      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      if (log_addr.size() < 3) begin
         tests++; fails++;
         $display("FAIL stream_len: got %0d fetches, expected at least 3", log_addr.size());
      end else begin
         check("stream_a0", log_addr[0], 32'h0);
         check("stream_a1", log_addr[1], 32'h4);
         check("stream_a2", log_addr[2], 32'h8);
         check("stream_gap", log_cyc[2] - log_cyc[1], 32'd2);
      end
      if (log2.size() < 2) begin
         tests++; fails++;
         $display("FAIL wrap_len: got %0d fetches, expected at least 2", log2.size());
      end else begin
         check("wrap_a0", log2[0], 32'hFFFF_FFFC);
         check("wrap_a1", log2[1], 32'h0);
      end

      max_lat = 3; rdy_pct = 50; redir_pct = 8;
      repeat (3000) @(posedge clk);

      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(posedge clk);
         #1;
         if (bus.imem_req) found = 1'b1;
      end
      check("req_seen_before_reset", {31'h0, found}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_req", {31'h0, bus.imem_req}, 32'h0);
      check("arst_valid", {31'h0, bus.instr_valid}, 32'h0);
      check("arst_addr", bus.imem_addr, 32'h0);
      check("arst_instr", bus.instr, NOP);
      d0 = n_deliv;
      redir_pct = 0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (30) @(posedge clk);
      redir_pct = 8;
      repeat (300) @(posedge clk);
      #2;
      check("restart_delivers", {31'h0, (n_deliv > d0 + 5)}, 32'h1);
      check("total_delivers", {31'h0, (n_deliv > 200)}, 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage of the RISC-V core, directly upstream of the immediate extender and the decoder.
- Holds the PC and issues word requests to instruction memory over a request/acknowledge handshake.
- Registers each returned instruction and presents it to decode with a valid/ready handshake.
- Supplies the extender's raw immediate field (instruction bits 31:7) and its IMM_SRC select (0 = load, 1 = store). Supports redirects from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
NOP_INSTR, 32'h0000_0013, value INSTR holds when no valid instruction (addi x0,x0,0).

Ports:
CLK  input  1  core clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
IMEM_REQ  output  1  fetch request, held until IMEM_ACK
IMEM_ADDR  output  32  word address of request, PC[1:0]=00
IMEM_ACK  input  1  memory acknowledge; IMEM_RDATA valid in same cycle
IMEM_RDATA  input  32  instruction word
INSTR_VALID  output  1  INSTR/INSTR_PC hold an unconsumed instruction
INSTR_READY  input  1  decode accepts instruction this cycle
INSTR  output  32  registered instruction
INSTR_PC  output  32  address of INSTR
NONE_EXTENDED_DATA  output  25  INSTR[31:7], to extender
IMM_SRC  output  1  1 when INSTR opcode = 7'b0100011 (store), else 0
REDIRECT_VALID  input  1  PC redirect request (branch/jump taken)
REDIRECT_PC  input  32  redirect target; bits [1:0] ignored, forced 00

Behaviour:
- Reset (RST_N low, asynchronous): PC=RESET_PC, state=IDLE, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR=NOP_INSTR, INSTR_PC=0. Hence IMM_SRC=0 and NONE_EXTENDED_DATA=NOP_INSTR[31:7].
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: lasts exactly one cycle after reset release, then moves to FETCH.
- FETCH: IMEM_REQ=1 and IMEM_ADDR=PC, both stable until the ACK cycle.
  - On IMEM_ACK (no redirect): INSTR<=IMEM_RDATA, INSTR_PC<=PC, INSTR_VALID<=1, PC<=PC+4, go to HOLD.
  - ACK is allowed in the first request cycle; minimum latency from request to INSTR_VALID is 1 cycle.
- HOLD: IMEM_REQ=0; INSTR, INSTR_PC and INSTR_VALID stay stable while INSTR_READY=0.
  - On INSTR_READY: INSTR_VALID<=0, INSTR<=NOP_INSTR, go to FETCH.
  - Peak throughput is one instruction per 2 cycles.
- IMM_SRC and NONE_EXTENDED_DATA are combinational from the INSTR register only, never from IMEM_RDATA.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Redirect (REDIRECT_VALID=1) has priority over every other event. In all cases PC<={REDIRECT_PC[31:2],2'b00} takes effect next cycle.
  - IDLE: go to FETCH.
  - FETCH with IMEM_ACK=0: the outstanding request is not cancellable. Go to DRAIN with IMEM_REQ and IMEM_ADDR held at the old PC.
  - FETCH with IMEM_ACK=1 in the same cycle: discard returned data, INSTR_VALID stays 0, go to FETCH (new request at target next cycle).
  - HOLD: held instruction discarded, INSTR_VALID<=0, INSTR<=NOP_INSTR, go to FETCH. This applies with or without INSTR_READY; with INSTR_READY=1 the handshake counts as completed.
  - DRAIN: a further redirect overwrites the target PC.
- DRAIN: IMEM_REQ=1 at the old address until IMEM_ACK; data discarded, INSTR_VALID stays 0. Then go to FETCH at the redirect PC.
- INSTR_READY while INSTR_VALID=0 is ignored.
- Reset asserted mid-transaction: all state returns to reset values immediately. The pending memory access is abandoned; the memory side must tolerate IMEM_REQ dropping without ACK.

Test Plan:
- Reset release, memory acks every request at once, INSTR_READY=1 always, IMEM_RDATA=32'h0082A183 (lw) at addr 0 -> IMEM_ADDR sequence 0,4,8 on alternate cycles; first INSTR=32'h0082A183, INSTR_PC=0, IMM_SRC=0, NONE_EXTENDED_DATA=25'h0010543.
- Store 32'h0062A423 fetched -> IMM_SRC=1 while INSTR_VALID; after consume, INSTR=32'h00000013 and IMM_SRC=0.
- Backpressure: INSTR_READY=0 for 5 cycles after valid -> INSTR/INSTR_PC stable, IMEM_REQ=0, PC unchanged; consume -> next request at PC+4.
- Redirect to 32'h0000_0102 during FETCH with ACK delayed 3 cycles -> IMEM_ADDR stays old until ACK, no INSTR_VALID; next request at 32'h0000_0100.
- RESET_PC=32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
- RST_N pulsed low while IMEM_REQ=1 in FETCH -> IMEM_REQ=0 and INSTR_VALID=0 asynchronously; after release, fetch restarts at RESET_PC.
